// File: rtl/dmem_stride_agu_pkg.sv
// dmem_stride_agu_pkg: shared types and default widths for the strided data-memory address generator
package dmem_stride_agu_pkg;
  localparam int DEF_WIDTH_ADDR = 10;
  localparam int DEF_WIDTH_LEN = 10;
  typedef enum logic [1:0] {IDLE, REQ, RUN} agu_state_t;
  typedef struct packed {
    logic req;
    logic [DEF_WIDTH_LEN-1:0] len;
    logic [DEF_WIDTH_ADDR-1:0] stride;
    logic [DEF_WIDTH_ADDR-1:0] base;
  } agu_cmd_t;
endpackage

// File: rtl/dmem_stride_agu.sv
// dmem_stride_agu: arbitrates for a memory port then emits one strided address per unstalled cycle
module dmem_stride_agu
  import dmem_stride_agu_pkg::*;
#(
  parameter int WIDTH_ADDR = DEF_WIDTH_ADDR,
  parameter int WIDTH_LEN = DEF_WIDTH_LEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Req,
  input  logic [WIDTH_LEN-1:0]  I_Length,
  input  logic [WIDTH_ADDR-1:0] I_Stride,
  input  logic [WIDTH_ADDR-1:0] I_Base_Addr,
  input  logic                  I_Grant,
  input  logic                  I_Stall,
  output logic                  O_Ready,
  output logic                  O_Req,
  output logic                  O_Valid,
  output logic [WIDTH_ADDR-1:0] O_Addr,
  output logic                  O_Term
);
  agu_state_t state;
  logic [WIDTH_LEN-1:0] len, count;
  logic [WIDTH_ADDR-1:0] stride, base, addr;
  logic run, last, beat;
  assign run = state == RUN;
  assign last = count == len - WIDTH_LEN'(1);
  assign beat = run && !I_Stall;
  assign O_Ready = state == IDLE;
  assign O_Req = state == REQ;
  assign O_Valid = beat;
  assign O_Addr = run ? addr : '0;
  assign O_Term = beat && last;
  // command latch, grant wait and per-element address/count stepping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      len <= '0;
      count <= '0;
      stride <= '0;
      base <= '0;
      addr <= '0;
    end else begin
      unique case (state)
        IDLE: if (I_Req && I_Length != '0) begin
          len <= I_Length;
          stride <= I_Stride;
          base <= I_Base_Addr;
          count <= '0;
          state <= REQ;
        end
        REQ: if (I_Grant) begin
          addr <= base;
          state <= RUN;
        end
        RUN: if (!I_Stall) begin
          if (last) state <= IDLE;
          else begin
            count <= count + WIDTH_LEN'(1);
            addr <= addr + stride;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
